dma_mem_arbiter: RTL
====================

# dma_mem_arbiter

Shares one single-port, word-addressed memory port between the DMA read requester (MM2S side) and the DMA write requester (S2MM side) of the loopback design. It sits between the DMA engine and the RAM model or BRAM and issues at most one memory access per cycle. Arbitration is burst-locked round-robin. Read responses are buffered in a 3-entry in-order FIFO, so reads sustain one access per cycle when the consumer is always ready.

## Interface
Parameters:
- AXI_WIDTH, 128, memory data width in bits; power of two, ≥ 16.
- AXI_ADDR_WIDTH, 32, byte-address width. Ports carry word addresses of AXI_ADDR_WIDTH-LSB bits.
- LSB, $clog2(AXI_WIDTH)-3, derived; not overridden.
- MAX_BURST, 16, maximum consecutive grants to the current owner while the other side waits; ≥ 1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  clock; all state on the rising edge.
  - rstn  in  1  synchronous reset, active low.
- Read request:
  - rd_req_valid  in  1  read request.
  - rd_req_ready  out  1  read request accepted this cycle.
  - rd_req_addr  in  AXI_ADDR_WIDTH-LSB  read word address.
- Read response:
  - rd_resp_valid  out  1  read data available.
  - rd_resp_ready  in  1  consumer accepts the read data.
  - rd_resp_data  out  AXI_WIDTH  read data, returned in request order.
- Write request:
  - wr_req_valid  in  1  write request.
  - wr_req_ready  out  1  write request accepted this cycle.
  - wr_req_addr  in  AXI_ADDR_WIDTH-LSB  write word address.
  - wr_req_data  in  AXI_WIDTH  write data.
  - wr_req_strb  in  AXI_WIDTH/8  byte enables.
- Memory side:
  - mem_ren  out  1  memory read strobe.
  - mem_wen  out  1  memory write strobe.
  - mem_addr  out  AXI_ADDR_WIDTH-LSB  memory word address.
  - mem_wdata  out  AXI_WIDTH  memory write data.
  - mem_strb  out  AXI_WIDTH/8  memory byte enables.
  - mem_rdata  in  AXI_WIDTH  memory read data; valid the cycle after mem_ren.

## Operation
- Effective requests:
  - er = rd_req_valid && credit_ok, where credit_ok = (fifo_count + inflight) < 3.
  - ew = wr_req_valid.
- State:
  - owner ∈ {RD, WR}; reset value RD.
  - burst_cnt, $clog2(MAX_BURST+1) bits; reset value 0.
  - inflight, 1 bit; reset value 0.
  - fifo_count, 0..3; reset value 0.
- Grant rule (combinational, one grant maximum per cycle):
  - Neither er nor ew: no grant; owner and burst_cnt hold.
  - Only one requests: grant it.
  - Both request, burst_cnt < MAX_BURST: grant owner.
  - Both request, burst_cnt == MAX_BURST: grant non-owner.
- Grant update:
  - Grant to owner: burst_cnt += 1.
  - Grant to non-owner: owner switches and burst_cnt = 1.
- Outputs:
  - rd_req_ready = grant_rd; wr_req_ready = grant_wr. Ready may depend on valid.
  - mem_ren = grant_rd; mem_wen = grant_wr.
  - mem_addr muxed from the granted requester; all zeros when idle.
  - mem_wdata and mem_strb = wr_req_data and wr_req_strb when grant_wr, otherwise zeros.
- Read return:
  - inflight <= grant_rd.
  - When inflight = 1, mem_rdata is pushed into the FIFO at the end of that cycle.
  - rd_resp_valid = fifo_count != 0; rd_resp_data = FIFO head.
  - A pop occurs on rd_resp_valid && rd_resp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - The credit check uses start-of-cycle counts; a same-cycle pop does not free credit.
- Credit invariant: the FIFO never overflows; fifo_count + inflight ≤ 3 at all times.

## Timing
- Reset (rstn low at a clock edge):
  - All state cleared at that edge: FIFO emptied, in-flight read discarded, owner = RD, burst_cnt = 0.
  - While rstn is low, rd_req_ready, wr_req_ready, mem_ren, mem_wen and rd_resp_valid are forced to 0.
  - A request presented in a reset cycle is not accepted and is not written.
- Write latency: 0. The memory write occurs in the accept cycle.
- Read latency:
  - Accept in cycle N → mem_ren in N.
  - mem_rdata sampled in N+1.
  - rd_resp_valid first high in N+2.
- Read throughput: with rd_resp_ready held at 1, one read per cycle is sustained.
- Read backpressure: with rd_resp_ready held at 0, at most 3 reads are accepted, then rd_req_ready = 0. The first pop re-enables grants in the following cycle.
- A write is never blocked by read credit; a credit-blocked read lets writes proceed.

## Test plan
- Reset: hold rstn=0 for 3 cycles with both valids high → all readies, mem_ren, mem_wen and rd_resp_valid = 0. After release, owner = RD, so the first contended grant goes to read.
- Single read, addr 0x10; model returns 0xA5A5…A5 the cycle after mem_ren → mem_ren and mem_addr=0x10 in cycle N; rd_resp_valid=1 with 0xA5…A5 in N+2.
- 8 back-to-back reads, addr 0..7, rd_resp_ready=1 → rd_req_ready high 8 consecutive cycles; responses returned in order, one per cycle, with no gaps.
- Backpressure: rd_resp_ready=0, continuous reads → exactly 3 accepted. Then set rd_resp_ready=1 → 3 responses in order, and accepts resume one cycle after the first pop.
- Contention, MAX_BURST=4, both valid continuously from reset → grant sequence R,R,R,R,W,W,W,W,R,R,R,R. Write: addr 5, strb 0x000F → mem_wen for exactly 1 cycle with matching mem_addr, mem_wdata and mem_strb.
- Reset mid-operation: assert rstn=0 with 2 responses queued and 1 read in flight → rd_resp_valid=0 after the edge; no stale response ever appears after release.

Source files
------------

// File: rtl/dma_mem_arbiter.sv
// dma_mem_arbiter: shares one single-port word-addressed memory between the
// DMA read requester and the DMA write requester. Burst-locked round-robin
// arbitration, at most one access per cycle, and read data returned in order
// through a 3-entry response FIFO protected by a credit check.
module dma_mem_arbiter #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LSB            = $clog2(AXI_WIDTH) - 3,
    parameter int MAX_BURST      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    // read request
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [AXI_ADDR_WIDTH-LSB-1:0] rd_req_addr,
    // read response
    output logic                          rd_resp_valid,
    input  logic                          rd_resp_ready,
    output logic [AXI_WIDTH-1:0]          rd_resp_data,
    // write request
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [AXI_ADDR_WIDTH-LSB-1:0] wr_req_addr,
    input  logic [AXI_WIDTH-1:0]          wr_req_data,
    input  logic [AXI_WIDTH/8-1:0]        wr_req_strb,
    // memory side
    output logic                          mem_ren,
    output logic                          mem_wen,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] mem_addr,
    output logic [AXI_WIDTH-1:0]          mem_wdata,
    output logic [AXI_WIDTH/8-1:0]        mem_strb,
    input  logic [AXI_WIDTH-1:0]          mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_t;

    owner_t               owner_q, owner_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           fifo_count_q, fifo_count_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [AXI_WIDTH-1:0] fifo_mem_q [3];
    logic [AXI_WIDTH-1:0] fifo_mem_d [3];

    logic credit_ok;
    logic er;
    logic ew;
    logic grant_rd;
    logic grant_wr;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Effective requests; credit uses start-of-cycle occupancy, and reset masks both sides.
    always_comb begin
        credit_ok = ({1'b0, fifo_count_q} + {2'b00, inflight_q}) < 3'd3;
        er        = rstn && rd_req_valid && credit_ok;
        ew        = rstn && wr_req_valid;
    end

    // Grant selection and owner/burst next-state.
    always_comb begin
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;

        if (er && ew) begin
            if (burst_cnt_q < BW'(MAX_BURST)) begin
                grant_rd = (owner_q == OWN_RD);
                grant_wr = (owner_q == OWN_WR);
            end else begin
                grant_rd = (owner_q == OWN_WR);
                grant_wr = (owner_q == OWN_RD);
            end
        end else begin
            grant_rd = er;
            grant_wr = ew;
        end

        // Counter saturates so an uncontended owner cannot wrap and starve the other side.
        if ((grant_rd && owner_q == OWN_RD) || (grant_wr && owner_q == OWN_WR)) begin
            if (burst_cnt_q != BW'(MAX_BURST)) begin
                burst_cnt_d = burst_cnt_q + BW'(1);
            end
        end else if (grant_rd || grant_wr) begin
            owner_d     = grant_rd ? OWN_RD : OWN_WR;
            burst_cnt_d = BW'(1);
        end
    end

    // Request handshakes and memory port drive from the single grant.
    always_comb begin
        rd_req_ready = grant_rd;
        wr_req_ready = grant_wr;
        mem_ren      = grant_rd;
        mem_wen      = grant_wr;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_strb     = '0;
        if (grant_rd) begin
            mem_addr = rd_req_addr;
        end else if (grant_wr) begin
            mem_addr  = wr_req_addr;
            mem_wdata = wr_req_data;
            mem_strb  = wr_req_strb;
        end
    end

    // Read return path: capture mem_rdata the cycle after mem_ren, pop on handshake.
    always_comb begin
        rd_resp_valid = rstn && (fifo_count_q != 2'd0);
        rd_resp_data  = fifo_mem_q[rd_ptr_q];
        push          = inflight_q;
        pop           = rd_resp_valid && rd_resp_ready;
        inflight_d    = grant_rd;

        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_q      <= OWN_RD;
            burst_cnt_q  <= '0;
            inflight_q   <= 1'b0;
            fifo_count_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            for (int unsigned i = 0; i < 3; i++) begin
                fifo_mem_q[i] <= fifo_mem_d[i];
            end
        end
    end

endmodule
